jk_bank_writer: RTL and testbench

- Write-side controller for an external bank of WIDTH JK flip-flops that share this block's clk and rst_n.
- Accepts a write request (valid/ready) and derives the per-bit target word from a mode and the bank's current q.
- Drives the JK excitation inputs for one cycle, then reads the bank back and compares it with the target.
- Retries on mismatch; reports done and error to the requester.

---
 rtl/jk_bank_writer_if.sv | 23 ++
 rtl/jk_bank_writer.sv | 112 +++++++++++
 tb/tb_jk_bank_writer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_writer_if.sv
// Requester-side handshake and status bundle for jk_bank_writer.
interface jk_bank_writer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_mode;
    logic [WIDTH-1:0] req_data;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] err_bits;

    modport master (
        output req_valid, req_mode, req_data,
        input  req_ready, busy, done, err, err_bits
    );

    modport slave (
        input  req_valid, req_mode, req_data,
        output req_ready, busy, done, err, err_bits
    );
endinterface

// File: rtl/jk_bank_writer.sv
// Write controller for an external JK flip-flop bank: derives a target word,
// drives one cycle of JK excitation, reads back, and retries on mismatch.
module jk_bank_writer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_bank_writer_if.slave  req,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out
);
    localparam int unsigned RETRY_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state;
    logic [RETRY_W-1:0] retry;
    logic [WIDTH-1:0]   target;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [WIDTH-1:0]   err_bits_q;
    logic [WIDTH-1:0]   acc_target_c;

    // Target word computed from the current bank contents at accept time
    always_comb begin
        acc_target_c = req.req_data;
        case (req.req_mode)
            2'b00:   acc_target_c = req.req_data;
            2'b01:   acc_target_c = q_in ^ req.req_data;
            2'b10:   acc_target_c = q_in & ~req.req_data;
            default: acc_target_c = q_in | req.req_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            retry      <= '0;
            target     <= '0;
            j_out      <= '0;
            k_out      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_bits_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            j_out  <= '0;
            k_out  <= '0;
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        target     <= acc_target_c;
                        retry      <= '0;
                        err_bits_q <= '0;
                        // Set-only / reset-only excitation: J&K is never issued
                        j_out      <= acc_target_c & ~q_in;
                        k_out      <= ~acc_target_c & q_in;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_in == target) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (retry < RETRY_W'(MAX_RETRY)) begin
                        retry <= retry + RETRY_W'(1);
                        j_out <= target & ~q_in;
                        k_out <= ~target & q_in;
                        state <= DRIVE;
                    end else begin
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        err_bits_q <= target ^ q_in;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign req.req_ready = ready_q;
    assign req.busy      = busy_q;
    assign req.done      = done_q;
    assign req.err       = err_q;
    assign req.err_bits  = err_bits_q;

endmodule

// File: tb/tb_jk_bank_writer.sv
// Bench for jk_bank_writer: JK bank model with stuck-at-0 faults, table
// vectors, hand sequences for reset corners, and random requests.
module tb_jk_bank_writer;
    localparam int unsigned W  = 8;
    localparam int unsigned MR = 2;

    typedef struct packed {
        logic         ready;
        logic         busy;
        logic         done;
        logic         err;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [W-1:0] eb;
    } obs_t;

    typedef struct {
        bit           preset_en;
        logic [W-1:0] preset;
        logic [W-1:0] s0;
        logic [1:0]   mode;
        logic [W-1:0] data;
        bit           hold;
        logic [W-1:0] tj;
        logic [W-1:0] tk;
        logic [W-1:0] teb;
        bit           terr;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] bank_q;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic         bank_wr;
    logic [W-1:0] bank_val;
    logic [W-1:0] stuck0;
    logic [W-1:0] model_q;
    int           n_cmp;
    int           n_bad;

    jk_bank_writer_if #(.WIDTH(W)) ifc ();

    jk_bank_writer #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (ifc),
        .q_in  (bank_q),
        .j_out (j_out),
        .k_out (k_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External JK bank sharing clk/rst_n; stuck0 bits never read back as 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else if (bank_wr) begin
            bank_q <= bank_val & ~stuck0;
        end else begin
            for (int b = 0; b < int'(W); b++) begin
                case ({j_out[b], k_out[b]})
                    2'b10:   bank_q[b] <= 1'b1 & ~stuck0[b];
                    2'b01:   bank_q[b] <= 1'b0;
                    2'b11:   bank_q[b] <= ~bank_q[b] & ~stuck0[b];
                    default: bank_q[b] <= bank_q[b] & ~stuck0[b];
                endcase
            end
        end
    end

    function automatic obs_t sample();
        obs_t o;
        o.ready = ifc.req_ready;
        o.busy  = ifc.busy;
        o.done  = ifc.done;
        o.err   = ifc.err;
        o.j     = j_out;
        o.k     = k_out;
        o.eb    = ifc.err_bits;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_preset(input logic [W-1:0] val);
        bank_wr  = 1'b1;
        bank_val = val;
        @(posedge clk);
        #1 bank_wr = 1'b0;
        @(negedge clk);
        model_q = val & ~stuck0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle
    task automatic run_op(input string tag, input logic [1:0] mode, input logic [W-1:0] data,
                          input bit hold, input bit use_tab, input logic [W-1:0] tj,
                          input logic [W-1:0] tk, input logic [W-1:0] teb, input bit terr);
        obs_t         exp_q[$];
        obs_t         e;
        obs_t         o;
        logic [W-1:0] q;
        logic [W-1:0] tgt;
        bit           ok;
        q = model_q;
        case (mode)
            2'b00:   tgt = data;
            2'b01:   tgt = q ^ data;
            2'b10:   tgt = q & ~data;
            default: tgt = q | data;
        endcase
        ok = 1'b0;
        for (int a = 0; a <= int'(MR); a++) begin
            e = '0; e.busy = 1'b1; e.j = tgt & ~q; e.k = ~tgt & q;
            exp_q.push_back(e);
            q = tgt & ~stuck0;
            e = '0; e.busy = 1'b1;
            exp_q.push_back(e);
            if (q == tgt) begin
                ok = 1'b1;
                break;
            end
        end
        e = '0; e.ready = 1'b1; e.done = 1'b1; e.err = !ok;
        e.eb = ok ? '0 : (tgt ^ q);
        exp_q.push_back(e);
        model_q = q;

        chk({tag, " ready_at_req"}, 64'(ifc.req_ready), 64'(1));
        ifc.req_valid = 1'b1;
        ifc.req_mode  = mode;
        ifc.req_data  = data;
        for (int n = 0; n < exp_q.size(); n++) begin
            @(posedge clk);
            #1;
            if (hold) begin
                ifc.req_valid = 1'b1;
                ifc.req_mode  = 2'($urandom);
                ifc.req_data  = W'($urandom);
            end else begin
                ifc.req_valid = 1'b0;
            end
            @(negedge clk);
            o = sample();
            chk($sformatf("%s cyc%0d", tag, n + 1), 64'(o), 64'(exp_q[n]));
            chk($sformatf("%s jk_excl cyc%0d", tag, n + 1), 64'(o.j & o.k), 64'(0));
            if (use_tab && n == 0) begin
                chk({tag, " tab_j"}, 64'(o.j), 64'(tj));
                chk({tag, " tab_k"}, 64'(o.k), 64'(tk));
            end
        end
        if (use_tab) begin
            chk({tag, " tab_err"}, 64'(ifc.err), 64'(terr));
            chk({tag, " tab_err_bits"}, 64'(ifc.err_bits), 64'(teb));
        end
        chk({tag, " bank"}, 64'(bank_q), 64'(model_q));
        if (hold) ifc.req_valid = 1'b0;
    endtask

    vec_t tab[7];

    initial begin
        obs_t o;
        n_cmp = 0;
        n_bad = 0;
        bank_wr = 1'b0;
        bank_val = '0;
        stuck0 = '0;
        model_q = '0;

        tab[0] = '{1'b1, 8'h00, 8'h00, 2'b00, 8'hA5, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0};
        tab[1] = '{1'b0, 8'h00, 8'h00, 2'b01, 8'h0F, 1'b0, 8'h0A, 8'h05, 8'h00, 1'b0};
        tab[2] = '{1'b0, 8'h00, 8'h00, 2'b10, 8'hA0, 1'b0, 8'h00, 8'hA0, 8'h00, 1'b0};
        tab[3] = '{1'b0, 8'h00, 8'h00, 2'b11, 8'h11, 1'b1, 8'h11, 8'h00, 8'h00, 1'b0};
        tab[4] = '{1'b0, 8'h00, 8'h00, 2'b00, 8'h1B, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tab[5] = '{1'b1, 8'h00, 8'h01, 2'b00, 8'h01, 1'b0, 8'h01, 8'h00, 8'h01, 1'b1};
        tab[6] = '{1'b1, 8'h3C, 8'h00, 2'b01, 8'hFF, 1'b0, 8'hC3, 8'h3C, 8'h00, 1'b0};

        // Reset with a request already pending
        rst_n = 1'b0;
        ifc.req_valid = 1'b1;
        ifc.req_mode  = 2'b00;
        ifc.req_data  = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = sample();
        chk("reset busy", 64'(o.busy), 64'(0));
        chk("reset outs", 64'({o.done, o.err, o.j, o.k, o.eb}), 64'(0));
        ifc.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        o = sample();
        chk("post_reset obs", 64'(o), 64'(obs_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00}));

        for (int i = 0; i < 7; i++) begin
            stuck0 = tab[i].s0;
            if (tab[i].preset_en) do_preset(tab[i].preset);
            run_op($sformatf("tab%0d", i), tab[i].mode, tab[i].data, tab[i].hold, 1'b1,
                   tab[i].tj, tab[i].tk, tab[i].teb, tab[i].terr);
        end
        stuck0 = '0;
        do_preset(8'h00);

        // Reset asserted in the middle of DRIVE
        ifc.req_valid = 1'b1;
        ifc.req_mode  = 2'b00;
        ifc.req_data  = 8'hFF;
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
        chk("midrst drive_j", 64'(j_out), 64'(8'hFF));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst j", 64'(j_out), 64'(0));
        chk("midrst k", 64'(k_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_q = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            o = sample();
            chk($sformatf("midrst idle cyc%0d", c), 64'(o),
                64'(obs_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00}));
        end

        // Randomized requests against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                stuck0 = ($urandom_range(0, 3) == 0) ? W'(1) << $urandom_range(0, W - 1) : '0;
                do_preset(W'($urandom));
            end
            run_op($sformatf("rnd%0d", i), 2'($urandom), W'($urandom),
                   bit'($urandom_range(0, 1)), 1'b0, '0, '0, '0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
